// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - core-side fetch and load/store request/response bus for sram_ctrl
interface sram_ctrl_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [17:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [17:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_be;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_rdata,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    output d_req_ready, d_rsp_valid, d_rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two-port 32-bit core to 16-bit async SRAM controller
// Optional feature macro: SRAM_CTRL_FETCH_BUF_EN (one-entry fetch buffer).
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus,
  output logic [16:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub,
  output logic        sram_lb,
  inout  wire  [15:0] sram_data
);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        last_fetch;   // 1: fetch port was served last (reset favours data)
  logic        port_fetch;
  logic        we_q;
  logic [15:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;         // reads carry 4'hF so both halves are always active
  logic [15:0] rd_lo;
  logic [15:0] dout_q;

  logic        grant_i;
  logic        grant_d;
  logic        acc_i;
  logic        acc_d;
  logic [15:0] a_word;
  logic        a_we;
  logic [3:0]  a_be;
  logic        phase_end;
  logic        fb_hit;
  logic [31:0] fb_rdata;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.i_req_addr[1:0], bus.d_req_addr[1:0]};

  assign grant_i = bus.i_req_valid && (!bus.d_req_valid || !last_fetch);
  assign grant_d = bus.d_req_valid && (!bus.i_req_valid ||  last_fetch);
  assign bus.i_req_ready = (state == IDLE) && !rst && grant_i;
  assign bus.d_req_ready = (state == IDLE) && !rst && grant_d;
  assign acc_i = bus.i_req_valid && bus.i_req_ready;
  assign acc_d = bus.d_req_valid && bus.d_req_ready;

  assign a_word    = acc_i ? bus.i_req_addr[17:2] : bus.d_req_addr[17:2];
  assign a_we      = acc_d && bus.d_req_we;
  assign a_be      = a_we ? bus.d_req_be : 4'hF;
  assign phase_end = (cnt == LAST_CNT);

  assign sram_data = sram_we_n ? 16'hzzzz : dout_q;

`ifdef SRAM_CTRL_FETCH_BUF_EN
  logic        fb_valid;
  logic [15:0] fb_word;
  logic [31:0] fb_data;

  assign fb_hit   = fb_valid && (fb_word == bus.i_req_addr[17:2]);
  assign fb_rdata = fb_data;

  // Remember the last completed fetch; any accepted write to that word invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_valid <= 1'b0;
      fb_word  <= '0;
      fb_data  <= '0;
    end else if (acc_d && bus.d_req_we && (bus.d_req_addr[17:2] == fb_word)) begin
      fb_valid <= 1'b0;
    end else if ((state == HI) && phase_end && port_fetch) begin
      fb_valid <= 1'b1;
      fb_word  <= word_q;
      fb_data  <= {sram_data, rd_lo};
    end
  end
`else
  assign fb_hit   = 1'b0;
  assign fb_rdata = 32'h0;
`endif

  // Sequencer: arbitration, halfword phases, registered SRAM pins and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      last_fetch      <= 1'b1;
      port_fetch      <= 1'b0;
      we_q            <= 1'b0;
      word_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      rd_lo           <= '0;
      dout_q          <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_rdata <= '0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_rdata <= '0;
      sram_addr       <= '0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_ub         <= 1'b0;
      sram_lb         <= 1'b0;
    end else begin
      bus.i_rsp_valid <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_i || acc_d) begin
            last_fetch <= acc_i;
            port_fetch <= acc_i;
            we_q       <= a_we;
            word_q     <= a_word;
            wdata_q    <= bus.d_req_wdata;
            be_q       <= a_be;
            cnt        <= '0;
            if (acc_i && fb_hit) begin
              state           <= RESP;
              bus.i_rsp_valid <= 1'b1;
              bus.i_rsp_rdata <= fb_rdata;
            end else if (|a_be[1:0]) begin
              state     <= LO;
              sram_addr <= {a_word, 1'b0};
              sram_ce_n <= 1'b0;
              sram_oe_n <= a_we;
              sram_we_n <= !a_we;
              sram_ub   <= a_be[1];
              sram_lb   <= a_be[0];
              dout_q    <= bus.d_req_wdata[15:0];
            end else if (|a_be[3:2]) begin
              state     <= HI;
              sram_addr <= {a_word, 1'b1};
              sram_ce_n <= 1'b0;
              sram_oe_n <= a_we;
              sram_we_n <= !a_we;
              sram_ub   <= a_be[3];
              sram_lb   <= a_be[2];
              dout_q    <= bus.d_req_wdata[31:16];
            end else begin
              state           <= RESP;
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_rdata <= '0;
            end
          end
        end
        LO: begin
          if (!phase_end) begin
            cnt <= cnt + 4'd1;
          end else begin
            rd_lo <= sram_data;
            cnt   <= '0;
            if (|be_q[3:2]) begin
              state     <= HI;
              sram_addr <= {word_q, 1'b1};
              sram_ce_n <= 1'b0;
              sram_oe_n <= we_q;
              sram_we_n <= !we_q;
              sram_ub   <= be_q[3];
              sram_lb   <= be_q[2];
              dout_q    <= wdata_q[31:16];
            end else begin
              // Only writes can end after LO; reads always need the upper half.
              state           <= RESP;
              sram_ce_n       <= 1'b1;
              sram_oe_n       <= 1'b1;
              sram_we_n       <= 1'b1;
              sram_ub         <= 1'b0;
              sram_lb         <= 1'b0;
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_rdata <= '0;
            end
          end
        end
        HI: begin
          if (!phase_end) begin
            cnt <= cnt + 4'd1;
          end else begin
            state     <= RESP;
            cnt       <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub   <= 1'b0;
            sram_lb   <= 1'b0;
            if (port_fetch) begin
              bus.i_rsp_valid <= 1'b1;
              bus.i_rsp_rdata <= {sram_data, rd_lo};
            end else begin
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_rdata <= we_q ? 32'h0 : {sram_data, rd_lo};
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Two-port controller between the core's 32-bit instruction-fetch and load/store ports and the board's 16-bit asynchronous SRAM (ego1 IS61WV12816BLL style pins). It arbitrates between the two requesters. Each 32-bit access is split into two sequenced 16-bit SRAM cycles, with a programmable wait state per halfword. It sits between the core memory interface and the top-level SRAM pins.

## Interface
- WAIT_CYCLES, 1, extra clk cycles each halfword access is held on the pins; legal range 0..15. N = WAIT_CYCLES+1.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted when valid&&ready
- i_req_addr  in  18  fetch byte address; [1:0] ignored
- i_rsp_valid  out  1  one-cycle pulse, fetch data valid
- i_rsp_rdata  out  32  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted when valid&&ready
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  18  data byte address; [1:0] ignored
- d_req_wdata  in  32  write data
- d_req_be  in  4  byte enables for writes; ignored on reads
- d_rsp_valid  out  1  one-cycle pulse, read data valid or write done
- d_rsp_rdata  out  32  read data; 0 on write responses
- sram_addr  out  17  halfword address
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_ub  out  1  upper byte enable, active-high
- sram_lb  out  1  lower byte enable, active-high
- sram_data  inout  16  data bus; driven only while sram_we_n=0

## Operation
- FSM states: IDLE, LO, HI, RESP.
- Ready is high only in IDLE, and only toward the granted requester.
- Arbitration is round-robin using a last-grant bit:
  - On simultaneous valids, the port not served last wins.
  - The reset value of the last-grant bit favours the data port.
- Halfword mapping:
  - LO uses sram_addr={addr[17:2],1'b0} and carries word bits [15:0].
  - HI uses sram_addr={addr[17:2],1'b1} and carries word bits [31:16].
  - LO: ub=be[1], lb=be[0]. HI: ub=be[3], lb=be[2]. Reads set ub=lb=1.
- Read halfword: ce_n=0, oe_n=0, we_n=1 for N cycles. sram_data is registered on the final cycle of the phase.
- Write halfword: ce_n=0, we_n=0, oe_n=1 for N cycles. sram_data is driven with the halfword for the whole phase.
- A write halfword whose two enable bits are both 0 is skipped: no pin activity, and the FSM advances immediately.
  - be=0000 goes IDLE→RESP directly.
- Transitions: IDLE→LO on accept, LO→HI, HI→RESP, RESP→IDLE.
- No response backpressure: the requester must accept the rsp_valid pulse.
- Between phases and in IDLE/RESP the pins are idle: ce_n=oe_n=we_n=1, ub=lb=0, sram_data hi-Z.
- sram_addr holds its last value while idle.
- Reset values:
  - ready outputs 0, rsp_valid 0, rdata 0.
  - ce_n/oe_n/we_n 1, ub/lb 0, sram_addr 0, sram_data hi-Z.
- Reset mid-transaction: the FSM returns to IDLE and pins go idle on the next edge. The in-flight request is dropped with no response.

## Timing
- The accept edge is T0. LO occupies T1..TN, HI occupies TN+1..T2N, and rsp_valid is high in T2N+1.
- ready is high again in T2N+2, which is the earliest next accept.
- With WAIT_CYCLES=1: read rsp_valid at T5; the next accept is possible at T6.
- A one-halfword write (e.g. be=0011) gives rsp_valid at TN+1. be=0000 gives rsp_valid at T1.
- rdata is valid only during the rsp_valid cycle and holds until the next response.

## Configuration
- SRAM_CTRL_FETCH_BUF_EN defined: one-entry fetch buffer holding {valid, word addr, data}.
  - It is filled on every completed fetch.
  - A fetch hit is accepted in IDLE and goes to RESP with no SRAM cycle, so i_rsp_valid is at T1.
  - Any accepted data write to the same word (any be, including 0000) clears valid.
  - rst clears valid.
- SRAM_CTRL_FETCH_BUF_EN undefined: no buffer is present, and every fetch performs two SRAM read halfwords.

## Test plan
- Data write 0xDEADBEEF, be=1111, addr 0x00010 → pins show halfword addr 0x0008 data 0xBEEF ub=lb=1, then 0x0009 data 0xDEAD. The following read returns 0xDEADBEEF at T5 (WAIT_CYCLES=1).
- Write be=0100, wdata=0x00AA0000 to the same word → LO phase skipped; HI phase has ub=0, lb=1. Read-back gives 0xDEAABEEF; d_rsp_valid for the write is at T3.
- Both valids held high for 3 transactions → grants alternate data, fetch, data. Ready is never high on both ports in the same cycle.
- Assert rst during the HI phase of a read → pins go idle next cycle and no d_rsp_valid appears. The next request completes normally with the data port winning a tie.
- With SRAM_CTRL_FETCH_BUF_EN: fetch 0x00010 twice → second response at T1 with no ce_n activity. A data write to 0x00012 followed by a fetch of 0x00010 triggers a full SRAM read returning the new data.
